// File: rtl/dice_roll_button_pkg.sv
// Shared types and constants for the dice roll-button front end.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } dice_btn_state_t;

  localparam int ROLL_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dice_roll_button_sync.sv
// Two-flop synchroniser for the asynchronous button level.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/dice_roll_button.sv
// Debounced roll-request generator: one roll strobe per accepted press,
// optional auto-repeat while held, and a wrapping count of issued rolls.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | synchronised level high, qualifying the press
// HELD         | press accepted; repeat timing runs here
// RELEASE_WAIT | synchronised level low, qualifying the release
module dice_roll_button
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_raw,
  output logic                  roll,
  output logic                  pressed,
  output logic [ROLL_CNT_W-1:0] roll_count
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic            s2;
  dice_btn_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic            rep_phase, rep_phase_n;
  logic            roll_n;
  logic            rep_due;

  btn_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (s2)
  );

  assign rep_due = rep_phase ? (cnt == PER_LAST) : (cnt == DLY_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rep_phase  <= 1'b0;
      roll       <= 1'b0;
      pressed    <= 1'b0;
      roll_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rep_phase  <= rep_phase_n;
      roll       <= roll_n;
      pressed    <= (state_n == HELD) || (state_n == RELEASE_WAIT);
      roll_count <= roll_count + ROLL_CNT_W'(roll_n);
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    rep_phase_n = rep_phase;
    roll_n      = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_n = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_n     = HELD;
          cnt_n       = '0;
          rep_phase_n = 1'b0;
          roll_n      = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end else if (REPEAT_EN != 0) begin
          if (rep_due) begin
            cnt_n       = '0;
            rep_phase_n = 1'b1;
            // a period of 1 would otherwise hold roll high back to back
            roll_n      = !roll;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_n     = HELD;
          cnt_n       = '0;
          rep_phase_n = 1'b0;
        end else if (cnt == DEB_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/dice_roll_button.md
# dice_roll_button

Debounced roll-request generator sitting directly upstream of the digital dice, turning a raw, bouncy, asynchronous push-button into the clean single-cycle `roll` strobe the dice consumes. It synchronises the button, qualifies press and release with a stability counter, and emits exactly one `roll` pulse per accepted press. An optional auto-repeat mode issues further pulses while the button is held. It also keeps a wrapping count of issued rolls for display and debug.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronised samples needed to accept a press or a release; must be ≥1.
- `REPEAT_EN`, 0: 1 enables auto-repeat while held.
- `REPEAT_DELAY`, 32: cycles from the initial pulse to the first repeat pulse; must be ≥1.
- `REPEAT_PERIOD`, 8: cycles between subsequent repeat pulses; must be ≥1.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  1  asynchronous, bouncy button level; 1 = pressed.
- `roll`  out  1  one-cycle strobe; connects to the dice `roll` input.
- `pressed`  out  1  debounced button level.
- `roll_count`  out  8  number of `roll` pulses issued, modulo 256.

## Operation
- Two-flop synchroniser: `btn_raw` → `s1` → `s2`. The FSM sees only `s2`.
- There is one shared counter `cnt`, sized `$clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD))+1` bits. Flag `rep_phase` is 0 during the delay and 1 once periodic repeat has started.
- FSM states and transitions:
  - IDLE:
    - `s2=1` → PRESS_WAIT, `cnt=0`.
  - PRESS_WAIT:
    - `s2=0` → IDLE (bounce rejected, no pulse).
    - Otherwise, if `cnt==DEBOUNCE_CYCLES-1` → HELD, with `cnt=0` and `rep_phase=0`.
    - Otherwise `cnt++`.
  - HELD:
    - `s2=0` → RELEASE_WAIT, `cnt=0`.
    - Otherwise, if `REPEAT_EN`:
      - When `rep_phase=0` and `cnt==REPEAT_DELAY-1`, or when `rep_phase=1` and `cnt==REPEAT_PERIOD-1`: fire a repeat pulse, set `cnt=0` and `rep_phase=1`.
      - Otherwise `cnt++`.
    - Otherwise (`REPEAT_EN=0`) `cnt` holds.
  - RELEASE_WAIT:
    - `s2=1` → HELD with `cnt=0` and `rep_phase=0`. No new pulse; the repeat delay restarts.
    - Otherwise, if `cnt==DEBOUNCE_CYCLES-1` → IDLE.
    - Otherwise `cnt++`.
- `roll` is registered. It is 1 for exactly one cycle:
  - on the first cycle in HELD after entry from PRESS_WAIT, and
  - on the cycle after each repeat pulse is fired.
- `roll` never stays high for two consecutive cycles.
- `pressed` is registered: 1 while in HELD or RELEASE_WAIT, 0 otherwise.
- `roll_count` increments by 1 in the same cycle `roll` is high, and wraps from 255 to 0.

## Timing
- Reset values, applied on any rising edge with `rst=1`:
  - `s1`, `s2` = 0
  - state = IDLE
  - `cnt` = 0, `rep_phase` = 0
  - `roll` = 0, `pressed` = 0, `roll_count` = 0
- `rst` has priority over every other event.
- Press latency: let edge k be the first edge sampling a stable `btn_raw=1` into `s1`.
  - `s2=1` after edge k+1.
  - PRESS_WAIT entered after edge k+2.
  - HELD entered, `roll=1` and `pressed=1` after edge k+D+2 (D = `DEBOUNCE_CYCLES`).
  - `roll` returns to 0 after edge k+D+3.
- Release latency: `pressed` falls D+2 edges after the first edge sampling `btn_raw=0`, with the same derivation.
- Repeat cadence: with the initial `roll` in cycle t:
  - first repeat `roll` in cycle t+`REPEAT_DELAY`;
  - subsequent repeats every `REPEAT_PERIOD` cycles.
- Button held through reset: after `rst` deasserts, the synchroniser refills and a full debounce runs. Exactly one `roll` appears D+2 edges after the first post-reset edge that samples the button.
- Reset mid-press or mid-repeat: any pending pulse is dropped and the sequence restarts from IDLE.

## Structure
- Package `dice_pkg`:
  - state typedef `dice_btn_state_t` (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - localparam `ROLL_CNT_W = 8`.
- Sub-module `btn_sync`: two-flop synchroniser with `clk`, `rst`, `d`, `q`; reset value 0.
- The top level `dice_roll_button` contains the FSM, counter, repeat logic and `roll_count`.

## Test plan
All scenarios use D=4, `REPEAT_EN=0` unless noted, 10 ns clock.
- Clean press: `btn_raw` 0→1 held for 20 cycles, then released → exactly one `roll` pulse 6 edges after the first sampling edge; `pressed` is 1 from that cycle until 6 edges after release; `roll_count` = 1.
- Bounce rejection: pattern 1,0,1,0,1 one cycle each, then 0 → no `roll`, `pressed` stays 0, `roll_count` stays 0.
- Release glitch: while held, a 2-cycle 0 glitch → `pressed` stays 1, no extra `roll`; after a real release, `pressed` falls.
- Auto-repeat (`REPEAT_EN=1`, `REPEAT_DELAY=8`, `REPEAT_PERIOD=4`): hold for 30 cycles after the initial `roll` at cycle t → pulses at t, t+8, t+12, t+16, …, t+28 (7 pulses); `roll_count` = 7.
- Wrap: 257 clean presses → `roll_count` = 1.
- Reset: assert `rst` for 1 cycle in PRESS_WAIT with the button still held → outputs clear; one `roll` issued after re-debounce; `roll_count` = 1.
